axis_pattern_source: RTL and testbench
======================================

# axis_pattern_source

Synthetic producer for the OPED consumer-side AXI4-Stream. It stands in for real input arbiters during DMA bring-up: it generates a programmed run of messages, each with a deterministic incrementing payload and LEN/SPT/DPT sideband, and drives them into the OPED slave stream. Because it honours backpressure, OPED DMA can be exercised without application logic.

## Interface
- GAP_CYCLES, 0: idle cycles inserted between consecutive messages of a run (0..255).
- ACLK  in  1  clock; all logic rising-edge.
- ARESETN  in  1  reset; asynchronous assert, active-low; one clock, no other clock domains.
- START  in  1  single-cycle run request; ignored while BUSY.
- CFG_LEN  in  16  message length in bytes; sampled on accepted START.
- CFG_COUNT  in  16  messages in run; sampled on accepted START.
- CFG_SPT, CFG_DPT  in  8 each  source/destination port tags; sampled on START.
- CFG_SEED  in  32  first payload word of run; sampled on START.
- CFG_ERR  in  1  flag every message of run as errored; sampled on START.
- BUSY  out  1  run in progress.
- DONE  out  1  one-cycle pulse at end of run.
- MSGS_SENT  out  16  messages completed in current/last run.
- M_AXIS_DAT_TDATA  out  256  payload, eight 32-bit words, word 0 in bits 31:0.
- M_AXIS_DAT_TVALID  out  1  beat valid.
- M_AXIS_DAT_TSTRB  out  32  byte enables, bit i for byte i.
- M_AXIS_DAT_TLAST  out  1  final beat of message.
- M_AXIS_DAT_TREADY  in  1  consumer ready.
- M_AXIS_LEN_TDATA  out  16  message byte length.
- M_AXIS_SPT_TDATA, M_AXIS_DPT_TDATA  out  8 each  port tags.
- M_AXIS_ERR_TVALID  out  1  error marker on TLAST beat.

## Operation
- States: IDLE, SEND, GAP. All outputs registered.
- IDLE: START latches CFG_*, clears MSGS_SENT, sets BUSY. CFG_COUNT=0 -> stay IDLE, DONE pulses next cycle, BUSY high only that one cycle, no beats. Else -> SEND.
- SEND: TVALID=1. A beat transfers when TVALID&TREADY. Beats per message = ceil(CFG_LEN/32); CFG_LEN=0 -> exactly one beat, TSTRB=0, TLAST=1.
- Non-final beats: TSTRB=all ones. Final beat: TSTRB low (CFG_LEN mod 32) bits set, all ones if mod is 0 and CFG_LEN>0.
- Payload: word k of beat = SEED + W + k, W = running word counter since START, +8 per transfer, 32-bit wrap; continues across messages (not reset per message). Zero-length beat consumes 8 words too. Bytes outside TSTRB still carry the pattern.
- LEN/SPT/DPT_TDATA = latched CFG_LEN/SPT/DPT, stable for every beat of the run. ERR_TVALID = CFG_ERR & TLAST.
- On TLAST transfer: MSGS_SENT+1. If MSGS_SENT+1==CFG_COUNT -> IDLE, BUSY low, DONE pulse. Else GAP_CYCLES=0 -> stay SEND (next message back-to-back); else -> GAP.
- GAP: TVALID=0 for exactly GAP_CYCLES cycles, then SEND. No gap after final message.

## Timing
- Reset values: TVALID, TLAST, ERR_TVALID, BUSY, DONE = 0; TDATA, TSTRB, LEN, SPT, DPT, MSGS_SENT = 0.
- START at edge N -> BUSY and first TVALID visible after edge N+1 (1 cycle latency).
- AXI rule: once TVALID is high, TDATA/TSTRB/TLAST/ERR/sideband held until transfer; TVALID never drops without transfer. Full throughput: one beat per cycle with TREADY held high.
- DONE high in the cycle after the final transfer, coincident with BUSY falling; new START accepted that same cycle.
- START while BUSY (including the DONE cycle's preceding cycle) ignored; CFG_* changes mid-run have no effect.
- ARESETN low mid-message: all outputs to reset values immediately, message truncated (no TLAST); on release, IDLE.

## Test plan
- LEN=64, COUNT=1, SEED=0, TREADY=1 -> 2 beats; beat0 words 0..7, beat1 words 8..15, TSTRB=FFFFFFFF both, TLAST on beat1, DONE one cycle later, MSGS_SENT=1.
- LEN=37, COUNT=2, SEED=0x100 -> 2 beats/msg; last TSTRB=0x1F; msg2 beat0 word0=0x110; LEN_TDATA=37 throughout.
- LEN=0, COUNT=3, CFG_ERR=1 -> 3 single beats, TSTRB=0, TLAST=1, ERR_TVALID=1 each.
- Random TREADY (50%), LEN=100, COUNT=4, GAP_CYCLES=3 -> outputs stable while stalled, exactly 3 TVALID-low cycles between messages, 16 transfers total.
- COUNT=0 -> DONE after 1 cycle, no TVALID; START during BUSY -> ignored, run unchanged.
- ARESETN pulsed mid-beat -> TVALID/BUSY 0 asynchronously; later START runs normally from SEED.

Source files
------------

// File: rtl/axis_pattern_source_if.sv
// Consumer-side AXI4-Stream bundle: payload beat plus per-message LEN/SPT/DPT sideband and error marker.
interface axis_pattern_source_if;
  logic [255:0] tdata;
  logic         tvalid;
  logic [31:0]  tstrb;
  logic         tlast;
  logic         tready;
  logic [15:0]  len_tdata;
  logic [7:0]   spt_tdata;
  logic [7:0]   dpt_tdata;
  logic         err_tvalid;

  modport master (
    output tdata, tvalid, tstrb, tlast, len_tdata, spt_tdata, dpt_tdata, err_tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tstrb, tlast, len_tdata, spt_tdata, dpt_tdata, err_tvalid,
    output tready
  );
endinterface

// File: rtl/axis_pattern_source.sv
// Programmed run of incrementing-payload messages; first beat one cycle after START, one beat/cycle at full rate.
// All outputs registered; beat contents held while tready is low, GAP_CYCLES idle cycles between messages.
module axis_pattern_source #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [15:0]           cfg_len_i,
  input  logic [15:0]           cfg_count_i,
  input  logic [7:0]            cfg_spt_i,
  input  logic [7:0]            cfg_dpt_i,
  input  logic [31:0]           cfg_seed_i,
  input  logic                  cfg_err_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           msgs_sent_o,
  axis_pattern_source_if.master m_axis
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  localparam logic [7:0] GAP_LD = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t        state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [15:0]   msgs_q, msgs_d, beat_q, beat_d, len_q, len_d, count_q, count_d;
  logic [31:0]   word_q, word_d, seed_q, seed_d;
  logic [7:0]    gap_q, gap_d, spt_q, spt_d, dpt_q, dpt_d;
  logic          err_q, err_d;
  logic          tvalid_q, tvalid_d, tlast_q, tlast_d, errtv_q, errtv_d;
  logic [31:0]   tstrb_q, tstrb_d;
  logic [255:0]  tdata_q, tdata_d;

  logic          ld, ld_err, ld_last;
  logic [15:0]   ld_len, ld_idx;
  logic [31:0]   ld_word, ld_seed;

  function automatic logic beat_is_last(input logic [15:0] len, input logic [15:0] idx);
    logic [16:0] nb;
    nb = ({1'b0, len} + 17'd31) >> 5;
    if (nb == 17'd0) nb = 17'd1;
    return ({1'b0, idx} == (nb - 17'd1));
  endfunction

  function automatic logic [31:0] strb_for(input logic [15:0] len, input logic last);
    logic [31:0] s;
    s = '1;
    if (last && len == 16'd0)           s = '0;
    else if (last && len[4:0] != 5'd0)  s = (32'd1 << len[4:0]) - 32'd1;
    return s;
  endfunction

  function automatic logic [255:0] pattern(input logic [31:0] base);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = base + 32'(k);
    return d;
  endfunction

  always_comb begin
    state_d  = state_q;  busy_d  = busy_q;  done_d = 1'b0;
    msgs_d   = msgs_q;   beat_d  = beat_q;  word_d = word_q;  gap_d = gap_q;
    len_d    = len_q;    count_d = count_q; spt_d  = spt_q;   dpt_d = dpt_q;
    seed_d   = seed_q;   err_d   = err_q;
    tvalid_d = tvalid_q; tlast_d = tlast_q; errtv_d = errtv_q;
    tstrb_d  = tstrb_q;  tdata_d = tdata_q;
    ld       = 1'b0;     ld_idx  = '0;      ld_word = word_q;
    ld_len   = len_q;    ld_seed = seed_q;  ld_err  = err_q;
    ld_last  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (busy_q) begin
          // Zero-message run: BUSY for one cycle, then DONE.
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (start_i) begin
          len_d   = cfg_len_i;   count_d = cfg_count_i;
          spt_d   = cfg_spt_i;   dpt_d   = cfg_dpt_i;
          seed_d  = cfg_seed_i;  err_d   = cfg_err_i;
          msgs_d  = '0;          word_d  = '0;  beat_d = '0;
          busy_d  = 1'b1;
          if (cfg_count_i != 16'd0) begin
            state_d = ST_SEND;
            ld      = 1'b1;
            ld_word = '0;
            ld_len  = cfg_len_i;
            ld_seed = cfg_seed_i;
            ld_err  = cfg_err_i;
          end
        end
      end
      ST_SEND: begin
        if (tvalid_q && m_axis.tready) begin
          word_d = word_q + 32'd8;
          if (tlast_q) begin
            msgs_d = msgs_q + 16'd1;
            beat_d = '0;
            if (msgs_q + 16'd1 == count_q) begin
              state_d  = ST_IDLE;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              tvalid_d = 1'b0; tlast_d = 1'b0; errtv_d = 1'b0;
            end else if (GAP_CYCLES == 0) begin
              ld      = 1'b1;
              ld_word = word_q + 32'd8;
            end else begin
              state_d  = ST_GAP;
              gap_d    = GAP_LD;
              tvalid_d = 1'b0; tlast_d = 1'b0; errtv_d = 1'b0;
            end
          end else begin
            beat_d  = beat_q + 16'd1;
            ld      = 1'b1;
            ld_idx  = beat_q + 16'd1;
            ld_word = word_q + 32'd8;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = ST_SEND;
          ld      = 1'b1;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ld) begin
      ld_last  = beat_is_last(ld_len, ld_idx);
      tvalid_d = 1'b1;
      tlast_d  = ld_last;
      errtv_d  = ld_err & ld_last;
      tstrb_d  = strb_for(ld_len, ld_last);
      tdata_d  = pattern(ld_seed + ld_word);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;  done_q  <= 1'b0;
      msgs_q   <= '0;    beat_q  <= '0;   word_q <= '0;  gap_q <= '0;
      len_q    <= '0;    count_q <= '0;   spt_q  <= '0;  dpt_q <= '0;
      seed_q   <= '0;    err_q   <= 1'b0;
      tvalid_q <= 1'b0;  tlast_q <= 1'b0; errtv_q <= 1'b0;
      tstrb_q  <= '0;    tdata_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;   done_q  <= done_d;
      msgs_q   <= msgs_d;   beat_q  <= beat_d;  word_q <= word_d;  gap_q <= gap_d;
      len_q    <= len_d;    count_q <= count_d; spt_q  <= spt_d;   dpt_q <= dpt_d;
      seed_q   <= seed_d;   err_q   <= err_d;
      tvalid_q <= tvalid_d; tlast_q <= tlast_d; errtv_q <= errtv_d;
      tstrb_q  <= tstrb_d;  tdata_q <= tdata_d;
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign msgs_sent_o       = msgs_q;
  assign m_axis.tdata      = tdata_q;
  assign m_axis.tvalid     = tvalid_q;
  assign m_axis.tstrb      = tstrb_q;
  assign m_axis.tlast      = tlast_q;
  assign m_axis.len_tdata  = len_q;
  assign m_axis.spt_tdata  = spt_q;
  assign m_axis.dpt_tdata  = dpt_q;
  assign m_axis.err_tvalid = errtv_q;

endmodule

// File: tb/tb_axis_pattern_source.sv
// Directed bench: dut0 runs back-to-back messages, dut3 inserts 3-cycle gaps under randomised backpressure.
module tb_axis_pattern_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start3 = 1'b0;
  logic [15:0] cfg_len = '0, cfg_count = '0;
  logic [7:0]  cfg_spt = '0, cfg_dpt = '0;
  logic [31:0] cfg_seed = '0;
  logic        cfg_err = 1'b0;
  logic        busy0, done0, busy3, done3;
  logic [15:0] msgs0, msgs3;

  int n_cmp = 0;
  int n_fail = 0;

  axis_pattern_source_if ax0();
  axis_pattern_source_if ax3();

  always #5 clk = ~clk;

  axis_pattern_source #(.GAP_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0),
    .cfg_len_i(cfg_len), .cfg_count_i(cfg_count), .cfg_spt_i(cfg_spt), .cfg_dpt_i(cfg_dpt),
    .cfg_seed_i(cfg_seed), .cfg_err_i(cfg_err),
    .busy_o(busy0), .done_o(done0), .msgs_sent_o(msgs0), .m_axis(ax0)
  );

  axis_pattern_source #(.GAP_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start3),
    .cfg_len_i(cfg_len), .cfg_count_i(cfg_count), .cfg_spt_i(cfg_spt), .cfg_dpt_i(cfg_dpt),
    .cfg_seed_i(cfg_seed), .cfg_err_i(cfg_err),
    .busy_o(busy3), .done_o(done3), .msgs_sent_o(msgs3), .m_axis(ax3)
  );

  function automatic logic [255:0] pat(input logic [31:0] base);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = base + 32'(k);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int xf, gap_n, seen_done;
    logic in_gap;

    ax0.tready = 1'b0;
    ax3.tready = 1'b0;

    // Reset state
    step(); step();
    chk("rst_tvalid", ax0.tvalid, 0);   chk("rst_tlast", ax0.tlast, 0);
    chk("rst_err", ax0.err_tvalid, 0);  chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);          chk("rst_tdata", ax0.tdata, 0);
    chk("rst_tstrb", ax0.tstrb, 0);     chk("rst_len", ax0.len_tdata, 0);
    chk("rst_spt", ax0.spt_tdata, 0);   chk("rst_dpt", ax0.dpt_tdata, 0);
    chk("rst_msgs", msgs0, 0);          chk("rst_tvalid3", ax3.tvalid, 0);
    rst_n = 1'b1;
    step();

    // Test 1: LEN=64 COUNT=1 SEED=0
    cfg_len = 16'd64; cfg_count = 16'd1; cfg_seed = 32'd0; cfg_err = 1'b0;
    ax0.tready = 1'b1; start0 = 1'b1;
    step(); start0 = 1'b0;
    chk("t1_busy", busy0, 1);           chk("t1_b0_valid", ax0.tvalid, 1);
    chk("t1_b0_data", ax0.tdata, pat(32'd0));
    chk("t1_b0_strb", ax0.tstrb, 32'hFFFF_FFFF);
    chk("t1_b0_last", ax0.tlast, 0);
    step();
    chk("t1_b1_data", ax0.tdata, pat(32'd8));
    chk("t1_b1_strb", ax0.tstrb, 32'hFFFF_FFFF);
    chk("t1_b1_last", ax0.tlast, 1);    chk("t1_b1_err", ax0.err_tvalid, 0);
    chk("t1_done_early", done0, 0);
    step();
    chk("t1_done", done0, 1);           chk("t1_busy_fall", busy0, 0);
    chk("t1_msgs", msgs0, 1);           chk("t1_valid_off", ax0.tvalid, 0);
    step();
    chk("t1_done_pulse", done0, 0);

    // Test 2: LEN=37 COUNT=2 SEED=0x100, START and CFG changes mid-run ignored
    cfg_len = 16'd37; cfg_count = 16'd2; cfg_seed = 32'h100;
    cfg_spt = 8'hA5; cfg_dpt = 8'h3C; start0 = 1'b1;
    step(); start0 = 1'b0;
    chk("t2_m1b0_data", ax0.tdata, pat(32'h100));
    chk("t2_m1b0_strb", ax0.tstrb, 32'hFFFF_FFFF);
    chk("t2_m1b0_last", ax0.tlast, 0);
    chk("t2_len", ax0.len_tdata, 37);
    chk("t2_spt", ax0.spt_tdata, 8'hA5); chk("t2_dpt", ax0.dpt_tdata, 8'h3C);
    cfg_len = 16'd5; cfg_seed = 32'hDEAD_0000; cfg_count = 16'd9; cfg_spt = 8'h11;
    start0 = 1'b1;
    step(); start0 = 1'b0;
    chk("t2_m1b1_data", ax0.tdata, pat(32'h108));
    chk("t2_m1b1_strb", ax0.tstrb, 32'h1F);
    chk("t2_m1b1_last", ax0.tlast, 1);
    step();
    chk("t2_m2b0_valid", ax0.tvalid, 1);
    chk("t2_m2b0_word0", ax0.tdata[31:0], 32'h110);
    chk("t2_m2b0_last", ax0.tlast, 0);   chk("t2_msgs_mid", msgs0, 1);
    chk("t2_len_mid", ax0.len_tdata, 37); chk("t2_spt_mid", ax0.spt_tdata, 8'hA5);
    step();
    chk("t2_m2b1_data", ax0.tdata, pat(32'h118));
    chk("t2_m2b1_strb", ax0.tstrb, 32'h1F);
    chk("t2_m2b1_last", ax0.tlast, 1);
    step();
    chk("t2_done", done0, 1);  chk("t2_msgs", msgs0, 2);  chk("t2_valid_off", ax0.tvalid, 0);
    step();
    chk("t2_stays_idle", busy0, 0);

    // Test 3: LEN=0 COUNT=3 ERR=1 -> single zero-strobe beats
    cfg_len = 16'd0; cfg_count = 16'd3; cfg_seed = 32'd5; cfg_err = 1'b1; start0 = 1'b1;
    step(); start0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_valid", ax0.tvalid, 1);      chk("t3_strb", ax0.tstrb, 0);
      chk("t3_last", ax0.tlast, 1);        chk("t3_err", ax0.err_tvalid, 1);
      chk("t3_data", ax0.tdata, pat(32'd5 + 32'(8 * i)));
      step();
    end
    chk("t3_done", done0, 1);  chk("t3_msgs", msgs0, 3);  chk("t3_err_off", ax0.err_tvalid, 0);
    cfg_err = 1'b0;

    // Test 4: dut3, LEN=100 COUNT=4 GAP=3, random backpressure, seed near wrap
    cfg_len = 16'd100; cfg_count = 16'd4; cfg_seed = 32'hFFFF_FFF0; start3 = 1'b1;
    step(); start3 = 1'b0;
    xf = 0; gap_n = 0; seen_done = 0; in_gap = 1'b0;
    for (int c = 0; c < 400 && seen_done == 0; c++) begin
      if (ax3.tvalid) begin
        if (in_gap) begin
          chk("t4_gap_len", gap_n, 3);
          in_gap = 1'b0;
        end
        chk("t4_data", ax3.tdata, pat(32'hFFFF_FFF0 + 32'(8 * xf)));
        chk("t4_last", ax3.tlast, (xf % 4) == 3);
        chk("t4_strb", ax3.tstrb, ((xf % 4) == 3) ? 32'h0000_000F : 32'hFFFF_FFFF);
        ax3.tready = 1'($urandom_range(0, 1));
        if (ax3.tready) begin
          if ((xf % 4) == 3 && xf != 15) begin
            in_gap = 1'b1;
            gap_n = 0;
          end
          xf++;
        end
      end else begin
        if (done3) seen_done = 1;
        else if (in_gap) gap_n++;
        ax3.tready = 1'($urandom_range(0, 1));
      end
      step();
    end
    chk("t4_done_seen", seen_done, 1);
    chk("t4_transfers", xf, 16);
    chk("t4_msgs", msgs3, 4);
    chk("t4_busy", busy3, 0);
    ax3.tready = 1'b0;

    // Test 5: COUNT=0, START during its BUSY cycle ignored, START in DONE cycle accepted
    cfg_count = 16'd0; start0 = 1'b1;
    step(); start0 = 1'b0;
    chk("t5_busy", busy0, 1);  chk("t5_valid", ax0.tvalid, 0);  chk("t5_done_early", done0, 0);
    cfg_count = 16'd2; cfg_len = 16'd64; start0 = 1'b1;
    step(); start0 = 1'b0;
    chk("t5_done", done0, 1);  chk("t5_busy_fall", busy0, 0);
    chk("t5_ignored", ax0.tvalid, 0);  chk("t5_msgs", msgs0, 0);
    cfg_count = 16'd1; cfg_len = 16'd32; cfg_seed = 32'h40; start0 = 1'b1;
    step(); start0 = 1'b0;
    chk("t5_restart_busy", busy0, 1);  chk("t5_restart_valid", ax0.tvalid, 1);
    chk("t5_restart_data", ax0.tdata, pat(32'h40));
    chk("t5_restart_last", ax0.tlast, 1);
    chk("t5_restart_strb", ax0.tstrb, 32'hFFFF_FFFF);
    step();
    chk("t5_restart_done", done0, 1);  chk("t5_restart_msgs", msgs0, 1);

    // Test 6: asynchronous reset mid-message, then a clean run
    cfg_len = 16'd256; cfg_count = 16'd2; cfg_seed = 32'h1000; start0 = 1'b1;
    step(); start0 = 1'b0;
    step();
    chk("t6_pre_valid", ax0.tvalid, 1);
    chk("t6_pre_data", ax0.tdata, pat(32'h1008));
    rst_n = 1'b0;
    #2;
    chk("t6_rst_valid", ax0.tvalid, 0);  chk("t6_rst_busy", busy0, 0);
    chk("t6_rst_data", ax0.tdata, 0);    chk("t6_rst_last", ax0.tlast, 0);
    chk("t6_rst_len", ax0.len_tdata, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("t6_post_idle", ax0.tvalid, 0);
    cfg_len = 16'd32; cfg_count = 16'd1; cfg_seed = 32'h77; start0 = 1'b1;
    step(); start0 = 1'b0;
    chk("t6_run_data", ax0.tdata, pat(32'h77));
    chk("t6_run_last", ax0.tlast, 1);    chk("t6_run_busy", busy0, 1);
    step();
    chk("t6_run_done", done0, 1);  chk("t6_run_msgs", msgs0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
